// File: rtl/mdr_pkg.sv
// Shared encodings for the memory data register port: access sizes, FSM states
// and the alignment rule used when a transaction is started.
package mdr_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // word_lo_nz: any of the word-offset address bits set; a0: address bit 0.
  function automatic logic access_bad(input logic [1:0] sz, input logic word_lo_nz,
                                      input logic a0);
    return (sz == SZ_RSVD) || ((sz == SZ_HALF) && a0) || ((sz == SZ_WORD) && word_lo_nz);
  endfunction

endpackage

// File: rtl/mdr_lane_align.sv
// Byte-lane steering between MDR and memory: read lane extract with sign/zero extension,
// write lane replication and byte-enable generation. Purely combinational, no flow control.
module mdr_lane_align
  import mdr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] rd_lane_i,
  input  logic [1:0]                  rd_size_i,
  input  logic                        sext_i,
  input  logic [DATA_W-1:0]           rdata_i,
  output logic [DATA_W-1:0]           rd_data_o,
  input  logic [$clog2(DATA_W/8)-1:0] wr_lane_i,
  input  logic [1:0]                  wr_size_i,
  input  logic [DATA_W-1:0]           wsrc_i,
  output logic [DATA_W-1:0]           wdata_o,
  output logic [DATA_W/8-1:0]         be_o
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  logic [LB-1:0] rd_pair;
  logic [LB-1:0] wr_pair;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;

  // Halfword accesses always use the even lane of the pair.
  always_comb begin
    rd_pair    = rd_lane_i;
    rd_pair[0] = 1'b0;
    wr_pair    = wr_lane_i;
    wr_pair[0] = 1'b0;
  end

  assign rd_byte = 8'(rdata_i >> {rd_lane_i, 3'b000});
  assign rd_half = 16'(rdata_i >> {rd_pair, 3'b000});

  always_comb begin
    rd_data_o = rdata_i;
    case (rd_size_i)
      SZ_BYTE: begin
        rd_data_o = DATA_W'(rd_byte);
        if (sext_i && rd_byte[7]) rd_data_o = rd_data_o | ~DATA_W'(8'hFF);
      end
      SZ_HALF: begin
        rd_data_o = DATA_W'(rd_half);
        if (sext_i && rd_half[15]) rd_data_o = rd_data_o | ~DATA_W'(16'hFFFF);
      end
      default: rd_data_o = rdata_i;
    endcase
  end

  always_comb begin
    wdata_o = wsrc_i;
    be_o    = '0;
    case (wr_size_i)
      SZ_BYTE: begin
        wdata_o = {NB{wsrc_i[7:0]}};
        be_o    = NB'(1) << wr_lane_i;
      end
      SZ_HALF: begin
        wdata_o = {(NB/2){wsrc_i[15:0]}};
        be_o    = NB'(3) << wr_pair;
      end
      SZ_WORD: begin
        wdata_o = wsrc_i;
        be_o    = '1;
      end
      default: begin
        wdata_o = wsrc_i;
        be_o    = '0;
      end
    endcase
  end

endmodule

// File: rtl/mdr_mem_port.sv
// Memory data register with byte/half/word memory handshake; req from start+1, done one cycle
// after ack (misaligned/reserved: done at start+1); memory stalls by withholding ack up to MAX_WAIT.
module mdr_mem_port
  import mdr_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DATA_W-1:0]     bus_in,
  input  logic                  MDRin,
  input  logic [ADDR_W-1:0]     addr_in,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic                  rd_start,
  input  logic                  wr_start,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic [DATA_W-1:0]     mdr_q,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int LB     = $clog2(DATA_W / 8);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic                sext_q;
  logic                we_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] be_q;
  logic                done_q;
  logic                err_q;

  logic                start;
  logic                bad;
  logic                timeout;
  logic [DATA_W-1:0]   rd_ext;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_be;

  assign start   = rd_start | wr_start;
  assign bad     = access_bad(size, addr_in[LB-1:0] != '0, addr_in[0]);
  // An ack in the last allowed cycle still completes normally.
  assign timeout = (state_q == ACCESS) && !mem_ack && (wait_q == WAIT_W'(MAX_WAIT - 1));

  // Write data is formed from the pre-load MDR at start, so a simultaneous MDRin cannot leak in.
  mdr_lane_align #(.DATA_W(DATA_W)) u_align (
    .rd_lane_i (addr_q[LB-1:0]),
    .rd_size_i (size_q),
    .sext_i    (sext_q),
    .rdata_i   (mem_rdata),
    .rd_data_o (rd_ext),
    .wr_lane_i (addr_in[LB-1:0]),
    .wr_size_i (size),
    .wsrc_i    (mdr_q),
    .wdata_o   (wr_data),
    .be_o      (wr_be)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !bad) state_d = ACCESS;
      ACCESS:  if (mem_ack || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    busy    = 1'b0;
    mem_we  = 1'b0;
    if (state_q == ACCESS) begin
      mem_req = 1'b1;
      busy    = 1'b1;
      mem_we  = we_q;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mdr_q   <= '0;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      we_q    <= 1'b0;
      wait_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (MDRin) mdr_q <= bus_in;
          if (start) begin
            addr_q <= addr_in;
            size_q <= size;
            sext_q <= sign_ext;
            we_q   <= wr_start;
            wait_q <= '0;
            err_q  <= bad;
            if (bad) begin
              done_q <= 1'b1;
            end else begin
              wdata_q <= wr_data;
              be_q    <= wr_be;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (!we_q) mdr_q <= rd_ext;
            done_q <= 1'b1;
          end else if (timeout) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Scoreboard bench for mdr_mem_port: driver pushes model expectations, a monitor pops them on done,
// and a responder plays the memory with programmable wait states.
module tb_mdr_mem_port;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 9;
  localparam int MAX_WAIT = 15;

  logic              clk;
  logic              clr;
  logic [31:0]       bus_in;
  logic              MDRin;
  logic [8:0]        addr_in;
  logic [1:0]        size;
  logic              sign_ext;
  logic              rd_start;
  logic              wr_start;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic [31:0]       mdr_q;
  logic [8:0]        mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_req;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic              err;

  mdr_mem_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .MDRin(MDRin), .addr_in(addr_in),
    .size(size), .sign_ext(sign_ext), .rd_start(rd_start), .wr_start(wr_start),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mdr_q(mdr_q), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_req(mem_req), .mem_we(mem_we),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mdr;
    logic        err;
    logic        chk_w;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [8:0]  addr;
    int          reqs;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          resp_waits = 0;
  logic [31:0] resp_rdata = '0;
  logic [31:0] model_mdr = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] d, input int lane, input int lane2,
                                           input logic [1:0] sz, input bit sx);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = (d >> (8 * lane)) & 32'hFF;
        if (sx && v >= 128) v = v - 256;
      end
      2'd1: begin
        v = (d >> (8 * lane2)) & 32'hFFFF;
        if (sx && v >= 32768) v = v - 65536;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  // Memory responder: acks after resp_waits request cycles (negative: never), random noise otherwise.
  initial begin
    int ctr;
    ctr = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (mem_req && !clr) begin
        if (ctr == resp_waits) begin
          mem_ack = 1'b1;
          mem_rdata = resp_rdata;
          ctr = 0;
        end else begin
          ctr++;
        end
      end else begin
        ctr = 0;
        mem_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: counts request cycles and scores each done pulse against the queue head.
  initial begin
    int          req_cnt;
    logic [8:0]  cap_addr;
    logic        cap_we;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    exp_t        e;
    req_cnt = 0;
    cap_addr = '0; cap_we = 1'b0; cap_wdata = '0; cap_be = '0;
    forever begin
      @(negedge clk);
      if (clr) begin
        req_cnt = 0;
      end else begin
        if (mem_req) begin
          req_cnt++;
          if (req_cnt == 1) begin
            cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata; cap_be = mem_be;
          end
        end
        if (done) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending transaction");
          end else begin
            e = expq.pop_front();
            check("done_mdr", mdr_q, e.mdr);
            check("done_err", 32'(err), 32'(e.err));
            check("req_cycles", 32'(req_cnt), 32'(e.reqs));
            if (e.reqs > 0) begin
              check("req_addr", 32'(cap_addr), 32'(e.addr));
              check("req_we", 32'(cap_we), 32'(e.chk_w));
              if (e.chk_w) begin
                check("wdata", cap_wdata, e.wdata);
                check("be", 32'(cap_be), 32'(e.be));
              end
            end
          end
          check("req_low_at_done", 32'(mem_req), 32'd0);
          check("busy_low_at_done", 32'(busy), 32'd0);
          req_cnt = 0;
          done_cnt++;
        end
      end
    end
  end

  task automatic clear_inputs();
    MDRin = 1'b0; rd_start = 1'b0; wr_start = 1'b0;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    @(negedge clk); #1;
    MDRin = 1'b1; bus_in = v;
    @(posedge clk); #1;
    clear_inputs();
    model_mdr = v;
    check("mdrin_load", mdr_q, v);
  endtask

  task automatic do_op(input bit wr, input bit rd, input bit ld, input logic [31:0] bus,
                       input logic [8:0] a, input logic [1:0] sz, input bit sx,
                       input logic [31:0] rdat, input int waits);
    exp_t        e;
    logic [31:0] old;
    bit          bad;
    int          lane, lane2, issued, budget;
    old   = model_mdr;
    if (ld) model_mdr = bus;
    bad   = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    lane  = a % 4;
    lane2 = lane - lane % 2;
    e = '{mdr: '0, err: 1'b0, chk_w: wr, wdata: '0, be: '0, addr: a, reqs: 0};
    if (bad) begin
      e.err = 1'b1;
      e.chk_w = 1'b0;
    end else if (waits < 0) begin
      e.err = 1'b1;
      e.reqs = MAX_WAIT;
    end else begin
      e.reqs = waits + 1;
      if (!wr) model_mdr = rd_model(rdat, lane, lane2, sz, sx);
    end
    if (wr && !bad) begin
      case (sz)
        2'd0: begin e.wdata = {24'd0, old[7:0]} * 32'h01010101; e.be = 4'(1 << lane); end
        2'd1: begin e.wdata = {16'd0, old[15:0]} * 32'h00010001; e.be = 4'(3 << lane2); end
        default: begin e.wdata = old; e.be = 4'hF; end
      endcase
    end
    e.mdr = model_mdr;
    expq.push_back(e);
    resp_waits = waits;
    resp_rdata = rdat;
    issued = done_cnt;
    wr_start = wr; rd_start = rd; MDRin = ld; bus_in = bus;
    addr_in = a; size = sz; sign_ext = sx;
    @(posedge clk); #1;
    clear_inputs();
    budget = 0;
    // While the access is still open, start/load requests must be ignored.
    while (done_cnt == issued && budget < 40) begin
      @(negedge clk); #1;
      budget++;
      if (done_cnt == issued) begin
        MDRin = $urandom_range(0, 1); bus_in = $urandom;
        rd_start = $urandom_range(0, 1); wr_start = $urandom_range(0, 1);
      end
    end
    clear_inputs();
    if (done_cnt == issued) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", budget);
    end
  endtask

  initial begin
    clr = 1'b1;
    bus_in = '0; MDRin = 1'b0; addr_in = '0; size = 2'd0; sign_ext = 1'b0;
    rd_start = 1'b0; wr_start = 1'b0;
    #3;
    check("rst_mdr", mdr_q, 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk); #1;
    clr = 1'b0;

    load_mdr(32'hDEADBEEF);
    check("load_req", 32'(mem_req), 32'd0);
    check("load_be", 32'(mem_be), 32'd0);
    check("load_err", 32'(err), 32'd0);

    do_op(0, 1, 0, '0, 9'h010, 2'd2, 0, 32'h12345678, 2);
    do_op(0, 1, 0, '0, 9'h003, 2'd0, 1, 32'h80FFFFFF, 0);
    check("byte_sx", mdr_q, 32'hFFFFFF80);
    do_op(0, 1, 0, '0, 9'h003, 2'd0, 0, 32'h80FFFFFF, 1);
    check("byte_zx", mdr_q, 32'h00000080);
    load_mdr(32'h0000ABCD);
    do_op(1, 0, 0, '0, 9'h002, 2'd1, 0, '0, 0);
    do_op(0, 1, 0, '0, 9'h001, 2'd1, 0, 32'h11112222, 0);
    do_op(0, 1, 0, '0, 9'h020, 2'd2, 0, 32'hCAFEF00D, -1);
    @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);
    do_op(0, 1, 0, '0, 9'h024, 2'd2, 0, 32'hCAFEF00D, MAX_WAIT - 1);
    do_op(0, 1, 0, '0, 9'h006, 2'd3, 0, '0, 0);
    do_op(1, 1, 0, '0, 9'h005, 2'd0, 0, 32'h55555555, 1);
    do_op(1, 0, 1, 32'h01020304, 9'h008, 2'd2, 0, '0, 0);
    do_op(0, 1, 1, 32'h0BADF00D, 9'h00E, 2'd1, 1, 32'h9ABC1234, 3);

    for (int i = 0; i < 150; i++) begin
      logic [8:0] a;
      logic [1:0] sz;
      int         w;
      int         kind;
      a  = 9'($urandom);
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      w = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 4));
      kind = $urandom_range(0, 2);
      do_op(kind != 1, kind != 0, $urandom_range(0, 3) == 0, $urandom, a, sz,
            $urandom_range(0, 1), $urandom, w);
    end

    @(negedge clk); #1;
    resp_waits = -1;
    addr_in = 9'h040; size = 2'd2; rd_start = 1'b1;
    @(posedge clk); #1;
    clear_inputs();
    repeat (3) @(negedge clk);
    check("clr_pre_req", 32'(mem_req), 32'd1);
    #2 clr = 1'b1;
    #1;
    check("clr_req_drop", 32'(mem_req), 32'd0);
    check("clr_busy_drop", 32'(busy), 32'd0);
    check("clr_mdr", mdr_q, 32'd0);
    model_mdr = '0;
    @(negedge clk); #1;
    clr = 1'b0;
    repeat (4) @(negedge clk);
    check("queue_drained", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdr_mem_port.md
# mdr_mem_port

Parametrised memory data register with an integrated memory-access handshake. It holds the MDR value, which is loaded either from the internal bus or from memory. It runs byte, halfword and word read/write transactions against the memory port, with lane alignment, sign/zero extension, misalignment detection and wait-state timeout. It sits between the datapath bus and the memory subsystem and replaces the fixed 32-bit, 2-input MDR.

## Interface
Parameters:
- DATA_W, 32, data width; multiple of 8, at least 16
- ADDR_W, 9, memory address width
- MAX_WAIT, 15, request cycles without ack before timeout (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset, asynchronous, active-high
- bus_in  in  DATA_W  datapath bus data
- MDRin  in  1  load MDR from bus_in (honoured in IDLE only)
- addr_in  in  ADDR_W  transaction address, captured at start
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- sign_ext  in  1  sign-extend byte/half reads (0 = zero-extend)
- rd_start  in  1  start read (IDLE only)
- wr_start  in  1  start write of MDR (IDLE only)
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion strobe
- mdr_q  out  DATA_W  MDR contents
- mem_addr  out  ADDR_W  registered transaction address
- mem_wdata  out  DATA_W  write data, lane-replicated
- mem_be  out  DATA_W/8  byte-lane enables
- mem_req  out  1  request, held until ack or timeout
- mem_we  out  1  write qualifier, valid with mem_req
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky: timeout, misalignment or reserved size

## Operation
- Reset values: mdr_q=0, mem_addr=0, mem_wdata=0, mem_be=0, mem_req=0, mem_we=0, busy=0, done=0, err=0, state IDLE, wait count 0.
- FSM states IDLE and ACCESS.
- IDLE:
  - MDRin loads bus_in.
  - rd_start or wr_start: captures addr_in, size and sign_ext, clears err, then checks the access.
  - Misaligned access (half with addr[0]=1, or word with addr low log2(DATA_W/8) bits ≠0) or size=11: set err, pulse done, stay IDLE, no mem_req.
  - Otherwise go to ACCESS.
- Start priority:
  - rd_start and wr_start together: the write wins.
  - MDRin together with wr_start: the write uses the old mdr_q, and MDR loads bus_in.
  - MDRin together with rd_start: the read result overwrites MDR later.
- ACCESS: mem_req=1, busy=1, and mem_we=1 for writes.
  - On mem_ack (reads): MDR takes the extracted lane(s), extended per sign_ext. Word reads take mem_rdata unchanged.
  - On mem_ack (reads and writes): return to IDLE and pulse done.
  - MDRin, rd_start and wr_start are ignored in ACCESS.
- Timeout: the wait counter increments each ACCESS cycle without ack. When it reaches MAX_WAIT: set err, pulse done, return to IDLE, MDR unchanged.
- mem_ack outside ACCESS is ignored.
- Lane selection: byte lane = addr low bits; halfword lane pair = addr low bits with bit0=0.
- Write data: byte replicates mdr_q[7:0] across all lanes; half replicates mdr_q[15:0]; mem_be one-hot or pair accordingly. Word writes use all ones.
- Sign extension uses the MSB of the selected lane(s).
- clr mid-transaction drops mem_req immediately (asynchronously) and discards the access; no done pulse.

## Timing
- Start sampled at edge t. mem_req is registered high from t+1.
- Zero-wait read: ack in cycle t+1, MDR updated at the end of t+1, mem_req low and done high in t+2.
- n wait cycles add n cycles to this latency.
- Misalignment: err and done high in t+1.
- Timeout: mem_req is high for exactly MAX_WAIT cycles, then err and done assert in the next cycle.
- A new start is accepted in the cycle done is high.

## Structure
- Package mdr_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum (IDLE, ACCESS)
- Sub-module mdr_lane_align, combinational:
  - read path: lane extract and extend
  - write path: replicate and mem_be generation

## Test plan
- Reset, then MDRin with bus_in=0xDEADBEEF -> mdr_q=0xDEADBEEF next cycle; all other outputs at reset values.
- Word read, addr 0x10, ack after 2 waits with mem_rdata=0x12345678 -> mem_req high 3 cycles, mdr_q=0x12345678, single done pulse.
- Byte read, addr 0x03, sign_ext=1, mem_rdata=0x80FFFFFF -> mdr_q=0xFFFFFF80; same with sign_ext=0 -> 0x00000080.
- Half write, addr 0x02, mdr_q=0x0000ABCD -> mem_wdata=0xABCDABCD, mem_be=1100, mem_we=1.
- Half read at addr 0x01 -> err=1 and done in t+1, no mem_req; no ack with MAX_WAIT=15 -> 15 req cycles then err, MDR unchanged.
- clr asserted mid-ACCESS -> mem_req drops without waiting for clk; rd_start and wr_start together -> write performed.
